// File: rtl/axi_dma_pkg.sv
// Shared constants, engine state encoding and width helper for the AXI DMA write engine.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } eng_state_e;

  // Bits needed to hold the values 0..n inclusive when n is a power of two.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/axi_dma_len_fifo.sv
// Small synchronous FIFO carrying burst lengths from the AW splitter to the W beat counter.
module axi_dma_len_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_dma_wr_engine.sv
// Descriptor-driven AXI write master: splits a transfer into 4 KB-safe bursts, streams FIFO
// beats onto W and tracks outstanding B responses.
module axi_dma_wr_engine
  import axi_dma_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 128,
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned AXI_ID          = 1,
  parameter int unsigned AXI_LEN_WIDTH   = 8,
  parameter int unsigned MAX_BURST_LEN   = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LEN_WIDTH       = 20
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [AXI_LEN_WIDTH-1:0]    awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_ID_WIDTH-1:0]     wid,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [AXI_ID_WIDTH-1:0]     bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [AXI_DATA_WIDTH-1:0]   if_rd_data,
  input  logic                        if_rd_valid,
  output logic                        if_rd_pop,
  output logic                        st_busy,
  output logic                        st_done,
  output logic                        st_error
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned BPB      = STRB_W;
  localparam int unsigned BEATS_4K = 4096 / BPB;
  localparam int unsigned SIZE_W   = $clog2(BPB);
  localparam int unsigned BLEN_W   = cnt_width(MAX_BURST_LEN);
  localparam int unsigned OUT_W    = cnt_width(MAX_OUTSTANDING);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);

  eng_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [OUT_W-1:0]          outst_q, outst_d;
  logic                      wact_q, wact_d;
  logic [BLEN_W-1:0]         wcnt_q, wcnt_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  logic [31:0]       rem_w, room_w, beats_w;
  logic              aw_hs, w_hs, b_hs;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [BLEN_W-1:0] fifo_rdata;

  // Burst size: bounded by what is left, the burst limit and the distance to the 4 KB page end.
  always_comb begin
    rem_w   = 32'(rem_q);
    room_w  = BEATS_4K - 32'(addr_q[11:0] >> SIZE_W);
    beats_w = rem_w;
    if (beats_w > MAX_BURST_LEN) beats_w = MAX_BURST_LEN;
    if (beats_w > room_w)        beats_w = room_w;
  end

  assign awid    = AXI_ID_WIDTH'(AXI_ID);
  assign wid     = AXI_ID_WIDTH'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_WIDTH'(beats_w - 1);
  assign awsize  = 3'(SIZE_W);
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state_q == StRun) && (rem_q != '0) &&
                   (outst_q != OUT_W'(MAX_OUTSTANDING)) && !fifo_full;
  assign aw_hs   = awvalid && awready;

  assign wvalid    = wact_q && if_rd_valid;
  assign wlast     = wact_q && (wcnt_q == BLEN_W'(1));
  assign wdata     = if_rd_data;
  assign wstrb     = '1;
  assign w_hs      = wvalid && wready;
  assign if_rd_pop = w_hs;
  // Load the next burst as soon as the W path is free, including right after wlast.
  assign fifo_pop  = !fifo_empty && (!wact_q || (w_hs && wlast));

  assign bready = 1'b1;
  assign b_hs   = bvalid && (bid == AXI_ID_WIDTH'(AXI_ID));

  assign cfg_ready = (state_q == StIdle);
  assign st_busy   = (state_q == StRun);
  assign st_done   = done_q;
  assign st_error  = err_q;

  axi_dma_len_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (BLEN_W)
  ) u_len_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (aw_hs),
    .wdata_i (BLEN_W'(beats_w)),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          addr_d = cfg_addr & ADDR_MASK;
          rem_d  = cfg_len;
          err_d  = 1'b0;
          if (cfg_len == '0) done_d = 1'b1;
          else               state_d = StRun;
        end
      end
      StRun: begin
        if (aw_hs) begin
          addr_d = addr_q + AXI_ADDR_WIDTH'(beats_w * BPB);
          rem_d  = rem_q - LEN_WIDTH'(beats_w);
        end
        if (b_hs && (bresp != AXI_RESP_OKAY)) err_d = 1'b1;
        if ((rem_q == '0) && !wact_q && fifo_empty && (outst_q == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({aw_hs, b_hs && (outst_q != '0)})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    wact_d = wact_q;
    wcnt_d = wcnt_q;
    if (fifo_pop) begin
      wact_d = 1'b1;
      wcnt_d = fifo_rdata;
    end else if (w_hs) begin
      wcnt_d = wcnt_q - 1'b1;
      if (wlast) wact_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      wact_q  <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      wact_q  <= wact_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axi_dma_wr_engine.sv
// Scoreboard bench for axi_dma_wr_engine: directed descriptors with hand-derived AW/W/done
// expectations, a slave/source model and a monitor that checks every handshake.
module tb_axi_dma_wr_engine;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [31:0]  cfg_addr = '0;
  logic [19:0]  cfg_len = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [0:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [0:0]   wid;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [0:0]   bid = 1'b1;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [127:0] if_rd_data = '0;
  logic         if_rd_valid = 1'b0;
  logic         if_rd_pop;
  logic         st_busy, st_done, st_error;

  aw_t  exp_aw[$];
  logic exp_w[$];
  logic exp_done[$];

  int n_chk = 0, n_pass = 0;
  int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, done_cnt = 0;
  int pending_b = 0, b_idx = 0, err_idx = -1;
  int src_idx = 0;
  bit pop_seen = 0, rand_mode = 0, b_hold = 0;
  bit prev_stall = 0;
  logic [31:0] prev_awaddr = '0;

  axi_dma_wr_engine #(
    .AXI_ADDR_WIDTH  (32),
    .AXI_DATA_WIDTH  (128),
    .AXI_ID_WIDTH    (1),
    .AXI_ID          (1),
    .AXI_LEN_WIDTH   (8),
    .MAX_BURST_LEN   (16),
    .MAX_OUTSTANDING (4),
    .LEN_WIDTH       (20)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .cfg_addr    (cfg_addr),
    .cfg_len     (cfg_len),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .awid        (awid),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .awburst     (awburst),
    .awvalid     (awvalid),
    .awready     (awready),
    .wid         (wid),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .wvalid      (wvalid),
    .wready      (wready),
    .bid         (bid),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .if_rd_data  (if_rd_data),
    .if_rd_valid (if_rd_valid),
    .if_rd_pop   (if_rd_pop),
    .st_busy     (st_busy),
    .st_done     (st_done),
    .st_error    (st_error)
  );

  initial forever #5 aclk = ~aclk;

  function automatic logic [127:0] pat(input int unsigned i);
    return {32'hD000_0000 + i, 32'hC000_0000 + i, 32'hB000_0000 + i, 32'hA000_0000 + i};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_burst(input logic [31:0] addr, input logic [7:0] len);
    aw_t e;
    e.addr = addr;
    e.len  = len;
    exp_aw.push_back(e);
    for (int i = 0; i <= int'(len); i++) exp_w.push_back(i == int'(len));
  endtask

  task automatic send(input logic [31:0] addr, input logic [19:0] len);
    int t = 0;
    @(posedge aclk); #1;
    while (!cfg_ready && t < 1000) begin
      @(posedge aclk); #1;
      t++;
    end
    cfg_addr  = addr;
    cfg_len   = len;
    cfg_valid = 1'b1;
    @(posedge aclk); #1;
    cfg_valid = 1'b0;
    @(negedge aclk);
    if (len != 0) begin
      chk("accept_awvalid_latency", awvalid, 1'b1);
      chk("accept_busy", st_busy, 1'b1);
      chk("accept_cfg_ready_low", cfg_ready, 1'b0);
      chk("accept_error_cleared", st_error, 1'b0);
    end else begin
      chk("zero_len_done_pulse", st_done, 1'b1);
      chk("zero_len_not_busy", st_busy, 1'b0);
    end
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(negedge aclk);
      t++;
    end
    chk(name, done_cnt, target);
  endtask

  // Slave and FIFO-source model, driven just after each rising edge.
  initial forever begin
    @(posedge aclk); #1;
    if (pop_seen) src_idx++;
    if_rd_data  = pat(src_idx);
    if_rd_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready      = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    awready     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (areset) begin
      pending_b = 0;
      bvalid    = 1'b0;
    end else if (pending_b > 0 && !b_hold) begin
      bvalid = 1'b1;
      bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
      b_idx++;
      pending_b--;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end
  end

  // Monitor: compares every AW/W handshake and done pulse against the queued expectations.
  initial forever begin
    @(negedge aclk);
    pop_seen = (if_rd_pop === 1'b1);
    if (!areset && prev_stall) begin
      chk("awvalid_held", awvalid, 1'b1);
      chk("awaddr_held", awaddr, prev_awaddr);
    end
    prev_stall  = !areset && (awvalid === 1'b1) && !awready;
    prev_awaddr = awaddr;
    if (awvalid === 1'b1 && awready) begin
      aw_t e;
      aw_cnt++;
      if (exp_aw.size() == 0) begin
        chk("aw_unexpected", awvalid, 1'b0);
      end else begin
        e = exp_aw.pop_front();
        chk("awaddr", awaddr, e.addr);
        chk("awlen", awlen, e.len);
        chk("awsize", awsize, 3'd4);
        chk("awburst", awburst, 2'b01);
      end
    end
    if (wvalid === 1'b1 && !wready) chk("no_pop_while_stalled", if_rd_pop, 1'b0);
    if (wvalid === 1'b1 && wready) begin
      chk("wdata_order", wdata, pat(w_cnt));
      w_cnt++;
      if (wlast) begin
        wlast_cnt++;
        pending_b++;
      end
      if (exp_w.size() == 0) chk("w_unexpected", wvalid, 1'b0);
      else chk("wlast", wlast, exp_w.pop_front());
    end
    if (st_done === 1'b1) begin
      done_cnt++;
      if (exp_done.size() == 0) chk("done_unexpected", st_done, 1'b0);
      else chk("st_error_at_done", st_error, exp_done.pop_front());
    end
  end

  initial begin
    int base_w, base_aw, base_l, base_d, t;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_pop", if_rd_pop, 1'b0);
    chk("rst_busy", st_busy, 1'b0);
    chk("rst_done", st_done, 1'b0);
    chk("rst_error", st_error, 1'b0);
    chk("bready_const", bready, 1'b1);
    chk("wstrb_const", wstrb, 16'hFFFF);
    @(posedge aclk); #1;
    areset = 1'b0;

    // 40 beats from 0x1000: 16 + 16 + 8.
    base_w = w_cnt; base_l = wlast_cnt;
    push_burst(32'h1000, 8'd15);
    push_burst(32'h1100, 8'd15);
    push_burst(32'h1200, 8'd7);
    exp_done.push_back(1'b0);
    send(32'h1000, 20'd40);
    wait_done("t1_done", 1, 2000);
    chk("t1_beats", w_cnt - base_w, 40);
    chk("t1_wlasts", wlast_cnt - base_l, 3);

    // 4 KB split; low address bits are dropped.
    push_burst(32'h0FC0, 8'd3);
    push_burst(32'h1000, 8'd3);
    exp_done.push_back(1'b0);
    send(32'h0FCF, 20'd8);
    wait_done("t2_done", 2, 2000);

    // B withheld: only MAX_OUTSTANDING bursts may be issued.
    b_hold = 1;
    base_aw = aw_cnt; base_w = w_cnt;
    for (int i = 0; i < 6; i++) push_burst(32'h2000 + 32'(i) * 32'h100, 8'd15);
    exp_done.push_back(1'b0);
    send(32'h2000, 20'd96);
    repeat (150) @(negedge aclk);
    chk("t3_aw_capped", aw_cnt - base_aw, 4);
    chk("t3_awvalid_off", awvalid, 1'b0);
    chk("t3_w_drained", w_cnt - base_w, 64);
    chk("t3_not_done", st_busy, 1'b1);
    @(posedge aclk); #1;
    b_hold = 0;
    wait_done("t3_done", 3, 2000);
    chk("t3_aw_total", aw_cnt - base_aw, 6);

    // SLVERR on the second of three bursts.
    err_idx = b_idx + 1;
    for (int i = 0; i < 3; i++) push_burst(32'h3000 + 32'(i) * 32'h100, 8'd15);
    exp_done.push_back(1'b1);
    send(32'h3000, 20'd48);
    wait_done("t4_done", 4, 2000);
    repeat (3) @(negedge aclk);
    chk("t4_error_sticky", st_error, 1'b1);
    chk("t4_idle_ready", cfg_ready, 1'b1);
    err_idx = -1;

    // Random source gaps, W stalls and AW stalls; crosses 4 KB first.
    rand_mode = 1;
    base_w = w_cnt; base_l = wlast_cnt;
    push_burst(32'h4F80, 8'd7);
    push_burst(32'h5000, 8'd15);
    push_burst(32'h5100, 8'd15);
    push_burst(32'h5200, 8'd9);
    exp_done.push_back(1'b0);
    send(32'h4F80, 20'd50);
    wait_done("t5_done", 5, 4000);
    rand_mode = 0;
    chk("t5_beats", w_cnt - base_w, 50);
    chk("t5_wlasts", wlast_cnt - base_l, 4);

    // Reset during the second burst: abort silently.
    base_w = w_cnt; base_d = done_cnt;
    for (int i = 0; i < 4; i++) push_burst(32'h6000 + 32'(i) * 32'h100, 8'd15);
    send(32'h6000, 20'd64);
    t = 0;
    while (w_cnt - base_w < 20 && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    chk("t6_reached_burst2", (w_cnt - base_w) >= 20, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("t6_awvalid_rst", awvalid, 1'b0);
    chk("t6_wvalid_rst", wvalid, 1'b0);
    chk("t6_cfg_ready_rst", cfg_ready, 1'b1);
    chk("t6_busy_rst", st_busy, 1'b0);
    chk("t6_done_rst", st_done, 1'b0);
    exp_aw.delete();
    exp_w.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t6_no_done", done_cnt - base_d, 0);

    base_aw = aw_cnt;
    exp_done.push_back(1'b0);
    send(32'h7000, 20'd0);
    repeat (5) @(negedge aclk);
    chk("t6_zero_len_no_aw", aw_cnt - base_aw, 0);
    chk("t6_zero_len_awvalid", awvalid, 1'b0);
    chk("t6_zero_len_done_cnt", done_cnt - base_d, 1);

    chk("aw_queue_drained", exp_aw.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
